cart_mem_arbiter: RTL and testbench
===================================

CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

Interface
REQ-001 Parameter MEM_AW, default 24: memory word-address width.
REQ-002 Parameter ROM_BASE, default 32'h1000_0000: base of the N64 cart ROM window.
REQ-003 Parameter ROM_MASK, default 32'h03FF_FFFF: offset mask of the ROM window.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: memory-ack watchdog limit, used only under ARB_TIMEOUT_EN.
REQ-005 Clock and reset: one clock, clk; reset rst, asynchronous, active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 n64_addr  in  32  bus-decoder address, byte address.
REQ-009 n64_addr_ready  in  1  bus-decoder level; each rising edge is one read request.
REQ-010 n64_data  out  16  read data for the cart bus driver.
REQ-011 n64_data_valid  out  1  one-cycle pulse; n64_data is new.
REQ-012 ldr_req  in  1  loader request, held until ldr_ack.
REQ-013 ldr_we  in  1  loader write (1) or read (0).
REQ-014 ldr_addr  in  MEM_AW  loader word address.
REQ-015 ldr_wdata  in  16  loader write data.
REQ-016 ldr_ack  out  1  one-cycle loader completion pulse.
REQ-017 ldr_rdata  out  16  loader read data, valid with ldr_ack.
REQ-018 mem_req  out  1  memory request, held until mem_ack.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  MEM_AW  memory word address.
REQ-021 mem_wdata  out  16  memory write data.
REQ-022 mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
REQ-023 mem_rdata  in  16  memory read data.
REQ-024 overrun  out  1  sticky flag: an N64 request was lost.
REQ-025 timeout  out  1  sticky flag: the watchdog fired.

Function
REQ-026 The block SHALL detect n64_addr_ready rising edges with a registered edge detector, and SHALL latch n64_addr into a one-deep pending slot in the detect cycle T.
REQ-027 The FSM SHALL have three states, IDLE, N64_RD and LDR_ACC; it SHALL arbitrate only in IDLE, with N64 pending having priority over ldr_req, and SHALL never preempt an access in progress.
REQ-028 IDLE -> N64_RD SHALL assert mem_req=1, mem_we=0, mem_addr=pending_addr[MEM_AW:1] in cycle T+1 when the FSM is idle at T.
REQ-029 A pending address outside the window ((addr & ~ROM_MASK) != ROM_BASE) SHALL issue no mem_req and SHALL pulse n64_data_valid with n64_data=16'h0000 at T+1.
REQ-030 In N64_RD, on mem_ack the block SHALL register mem_rdata to n64_data, pulse n64_data_valid in the next cycle, drop mem_req, clear pending and go to IDLE.
REQ-031 IDLE -> LDR_ACC SHALL drive mem_* from ldr_*; on mem_ack the block SHALL pulse ldr_ack the next cycle with ldr_rdata=mem_rdata (reads) and return to IDLE.
REQ-032 An N64 edge arriving during LDR_ACC SHALL be held pending and served immediately after that access completes.
REQ-033 A second N64 edge while the slot is still pending and unissued SHALL overwrite the slot and set overrun.
REQ-034 An edge coinciding with the clear of the previous request SHALL be retained.
REQ-035 n64_data SHALL hold its value between pulses.
REQ-036 mem_* outputs SHALL be stable while mem_req=1.

Reset
REQ-037 rst SHALL force, asynchronously: IDLE, pending cleared, edge history 0, and all outputs 0 (n64_data=0, overrun=0, timeout=0).
REQ-038 Reset mid-access SHALL drop mem_req immediately; the aborted access SHALL produce no ack or valid pulse.

Configuration
REQ-039 With macro ARB_TIMEOUT_EN defined, an 8-bit-minimum counter SHALL run while mem_req=1; at TIMEOUT_CYCLES without mem_ack the block SHALL drop mem_req, set timeout, return to IDLE, and complete the access with data 16'hDEAD.
REQ-040 With ARB_TIMEOUT_EN defined, an N64 read completion SHALL be n64_data_valid and a loader completion SHALL be ldr_ack.
REQ-041 Without ARB_TIMEOUT_EN the block SHALL wait for mem_ack indefinitely, and timeout SHALL be tied 0.

Structure
REQ-042 Package cart_pkg SHALL hold the FSM state enum, the ROM_BASE and ROM_MASK defaults, MEM_AW, and the 16'hDEAD constant.
REQ-043 One sub-module, edge_detect (2-flop synchroniser plus rise/fall outputs), SHALL be instantiated for n64_addr_ready.

Verification
REQ-044 Stimulus n64_addr=32'h1000_0040 edge, mem_ack 3 cycles later -> mem_addr=24'h000020, mem_we=0; n64_data_valid with the acked data one cycle after ack.
REQ-045 Stimulus n64_addr=32'h0500_0000 edge -> no mem_req; n64_data=16'h0000 with valid at T+1.
REQ-046 Stimulus: loader write to 24'h000100 in progress, N64 edge arrives -> ldr_ack first, then mem_req for the N64 address in the cycle after ldr_ack completes; overrun stays 0.
REQ-047 Stimulus: two N64 edges during one loader access -> only the second address is issued; overrun=1.
REQ-048 Stimulus (ARB_TIMEOUT_EN): mem_ack never arrives -> mem_req drops after 255 cycles; n64_data=16'hDEAD with valid; timeout=1.
REQ-049 Stimulus: rst asserted mid N64_RD -> mem_req=0 asynchronously, no valid pulse, all flags 0.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared types and constants for the N64 cart memory arbiter.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    N64_RD,
    LDR_ACC
  } state_e;

  localparam int          MEM_AW_DEF   = 24;
  localparam logic [31:0] ROM_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] ROM_MASK_DEF = 32'h03FF_FFFF;
  localparam logic [15:0] DEAD_DATA    = 16'hDEAD;

  function automatic logic in_rom(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (a & ~mask) == base;
  endfunction

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Word-wide memory request bus shared by the N64 and loader paths.
interface cart_mem_arbiter_if
  import cart_pkg::*;
#(
  parameter int AW = MEM_AW_DEF
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack;
  logic [15:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cart_mem_arbiter_edge_detect.sv
// Two-flop synchroniser with registered rise/fall strobes.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[0] & ~sync_q[1];
  assign fall = ~sync_q[0] & sync_q[1];

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates cart ROM reads and loader accesses onto one memory port.
// Define ARB_TIMEOUT_EN to enable the memory-ack watchdog.
module cart_mem_arbiter
  import cart_pkg::*;
#(
  parameter int          MEM_AW         = MEM_AW_DEF,
  parameter logic [31:0] ROM_BASE       = ROM_BASE_DEF,
  parameter logic [31:0] ROM_MASK       = ROM_MASK_DEF,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        n64_addr,
  input  logic               n64_addr_ready,
  output logic [15:0]        n64_data,
  output logic               n64_data_valid,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic [MEM_AW-1:0]  ldr_addr,
  input  logic [15:0]        ldr_wdata,
  output logic               ldr_ack,
  output logic [15:0]        ldr_rdata,
  cart_mem_arbiter_if.master mem,
  output logic               overrun,
  output logic               timeout
);

  state_e state_q, state_d;

  logic              pend_q, pend_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              lack_q, lack_d;
  logic [15:0]       lrdata_q, lrdata_d;
  logic              ovr_q, ovr_d;

  logic              rise;
  logic              n64_go;
  logic [31:0]       n64_a;

`ifdef ARB_TIMEOUT_EN
  localparam int CLW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLW > 8) ? CLW : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  edge_detect u_rdy_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (n64_addr_ready),
    .rise (rise),
    .fall ()
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    lack_d      = 1'b0;
    lrdata_d    = lrdata_q;
    ovr_d       = ovr_q;
    n64_go      = pend_q | rise;
    n64_a       = pend_q ? pend_addr_q : n64_addr;

    // An issued read leaves the slot, so only unissued requests can be lost.
    if (rise) begin
      pend_d      = 1'b1;
      pend_addr_d = n64_addr;
      if (pend_q && state_q != IDLE) begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (n64_go) begin
          pend_d = pend_q & rise;
          if (in_rom(n64_a, ROM_BASE, ROM_MASK)) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = n64_a[MEM_AW:1];
            state_d = N64_RD;
          end else begin
            valid_d = 1'b1;
            data_d  = '0;
          end
        end else if (ldr_req && !lack_q) begin
          // lack_q masks the loader's still-held request in its ack cycle.
          req_d   = 1'b1;
          we_d    = ldr_we;
          addr_d  = ldr_addr;
          wdata_d = ldr_wdata;
          state_d = LDR_ACC;
        end
      end
      N64_RD: begin
        if (mem.mem_ack) begin
          data_d  = mem.mem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      LDR_ACC: begin
        if (mem.mem_ack) begin
          lack_d  = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            lrdata_d = mem.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    cnt_d = req_q ? cnt_q + 1'b1 : '0;
    tmo_d = tmo_q;
    if (req_q && !mem.mem_ack &&
        cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      req_d   = 1'b0;
      tmo_d   = 1'b1;
      state_d = IDLE;
      if (state_q == N64_RD) begin
        valid_d = 1'b1;
        data_d  = DEAD_DATA;
      end else begin
        lack_d   = 1'b1;
        lrdata_d = DEAD_DATA;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      lack_q      <= 1'b0;
      lrdata_q    <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      lack_q      <= lack_d;
      lrdata_q    <= lrdata_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign n64_data       = data_q;
  assign n64_data_valid = valid_q;
  assign ldr_ack        = lack_q;
  assign ldr_rdata      = lrdata_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter with a latency-programmable memory.
module tb_cart_mem_arbiter;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] MASK = 32'h03FF_FFFF;

  typedef struct packed {
    logic        we;
    logic [23:0] a;
    logic [15:0] d;
  } mexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] n64_addr;
  logic        n64_addr_ready;
  logic [15:0] n64_data;
  logic        n64_data_valid;
  logic        ldr_req;
  logic        ldr_we;
  logic [23:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_ack;
  logic [15:0] ldr_rdata;
  logic        overrun;
  logic        timeout;

  cart_mem_arbiter_if #(.AW(24)) mem_if ();

  cart_mem_arbiter #(.MEM_AW(24)) dut (
    .clk            (clk),
    .rst            (rst),
    .n64_addr       (n64_addr),
    .n64_addr_ready (n64_addr_ready),
    .n64_data       (n64_data),
    .n64_data_valid (n64_data_valid),
    .ldr_req        (ldr_req),
    .ldr_we         (ldr_we),
    .ldr_addr       (ldr_addr),
    .ldr_wdata      (ldr_wdata),
    .ldr_ack        (ldr_ack),
    .ldr_rdata      (ldr_rdata),
    .mem            (mem_if),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n64_cnt = 0;
  int ack_cyc = 0;
  int req_cyc = 0;
  int mem_lat = 3;
  bit noack = 1'b0;

  logic [15:0] n64_exp[$];
  int          ldr_exp[$];
  mexp_t       addr_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [23:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // memory model: checks each new request, acks after mem_lat cycles
  initial begin
    bit    busy;
    int    lat;
    mexp_t cur;
    mexp_t e;
    busy = 1'b0;
    lat = 0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (mem_if.mem_req && !busy) begin
          busy = 1'b1;
          lat = 0;
          req_cyc = cyc;
          cur = {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
          if (addr_exp.size() == 0) begin
            chk("mem_unexpected_req", 1, 0);
          end else begin
            e = addr_exp.pop_front();
            chk("mem_we", mem_if.mem_we, e.we);
            chk("mem_addr", mem_if.mem_addr, e.a);
            if (e.we) chk("mem_wdata", mem_if.mem_wdata, e.d);
          end
        end
        if (busy) begin
          if (!mem_if.mem_req) begin
            busy = 1'b0;
          end else begin
            if (lat == mem_lat && !noack) begin
              chk("mem_stable",
                  {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, cur);
              mem_if.mem_ack = 1'b1;
              mem_if.mem_rdata = mdata(mem_if.mem_addr);
            end
            lat++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (n64_data_valid) begin
        n64_cnt++;
        if (n64_exp.size() == 0) chk("n64_unexpected_valid", 1, 0);
        else chk("n64_data", n64_data, n64_exp.pop_front());
      end
      if (ldr_ack) begin
        ack_cyc = cyc;
        if (ldr_exp.size() == 0) begin
          chk("ldr_unexpected_ack", 1, 0);
        end else begin
          int x;
          x = ldr_exp.pop_front();
          if (x >= 0) chk("ldr_rdata", ldr_rdata, x);
        end
      end
    end
  end

  task automatic n64_edge(input logic [31:0] a, input bit push, input bit to);
    mexp_t e;
    if (push) begin
      if ((a & ~MASK) != BASE) begin
        n64_exp.push_back(16'h0000);
      end else begin
        e.we = 1'b0;
        e.a = a[24:1];
        e.d = '0;
        addr_exp.push_back(e);
        n64_exp.push_back(to ? 16'hDEAD : mdata(a[24:1]));
      end
    end
    @(negedge clk);
    n64_addr = a;
    n64_addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    n64_addr_ready = 1'b0;
  endtask

  task automatic ldr_access(input logic we, input logic [23:0] a,
                            input logic [15:0] d);
    mexp_t e;
    int k;
    e.we = we;
    e.a = a;
    e.d = d;
    addr_exp.push_back(e);
    ldr_exp.push_back(we ? -1 : int'(mdata(a)));
    @(negedge clk);
    ldr_req = 1'b1;
    ldr_we = we;
    ldr_addr = a;
    ldr_wdata = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ldr_ack && k < 400);
    chk("ldr_ack_seen", ldr_ack, 1);
    ldr_req = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((n64_exp.size() != 0 || ldr_exp.size() != 0 ||
            addr_exp.size() != 0 || mem_if.mem_req) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", k < lim, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int base;
    rst = 1'b0;
    n64_addr = '0;
    n64_addr_ready = 1'b0;
    ldr_req = 1'b0;
    ldr_we = 1'b0;
    ldr_addr = '0;
    ldr_wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_n64_data", n64_data, 0);
    chk("rst_valid", n64_data_valid, 0);
    chk("rst_ldr_ack", ldr_ack, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // in-window read, ack three cycles after the request
    n64_edge(32'h1000_0040, 1, 0);
    chk("rd_req_t1", mem_if.mem_req, 1);
    chk("rd_addr_t1", mem_if.mem_addr, 24'h000020);
    chk("rd_we_t1", mem_if.mem_we, 0);
    k = 0;
    while (!n64_data_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_valid_latency", k, 4);
    repeat (3) @(negedge clk);
    chk("rd_data_hold", n64_data, mdata(24'h000020));

    // out-of-window read answers zero without touching memory
    n64_edge(32'h0500_0000, 1, 0);
    chk("oow_valid_t1", n64_data_valid, 1);
    chk("oow_data_t1", n64_data, 16'h0000);
    chk("oow_no_req", mem_if.mem_req, 0);
    drain(50);

    ldr_access(1'b0, 24'h000042, 16'h0000);
    drain(50);

    // N64 edge during a loader write is served right after ldr_ack
    mem_lat = 6;
    fork
      ldr_access(1'b1, 24'h000100, 16'hBEEF);
      begin
        @(negedge clk);
        n64_edge(32'h1000_0080, 1, 0);
      end
    join
    drain(100);
    chk("n64_after_ldr_ack", req_cyc, ack_cyc + 1);
    chk("ovr_single_edge", overrun, 0);

    // two edges during one loader read: only the second is issued
    mem_lat = 10;
    base = n64_cnt;
    fork
      ldr_access(1'b0, 24'h000200, 16'h0000);
      begin
        @(negedge clk);
        n64_edge(32'h1000_0100, 0, 0);
        n64_edge(32'h1000_0200, 1, 0);
      end
    join
    drain(100);
    chk("ovr_double_edge", overrun, 1);
    chk("double_edge_valids", n64_cnt - base, 1);

`ifdef ARB_TIMEOUT_EN
    noack = 1'b1;
    n64_edge(32'h1000_0300, 1, 1);
    k = 0;
    while (mem_if.mem_req && k < 400) begin
      k++;
      @(negedge clk);
    end
    chk("to_req_cycles", k, 255);
    noack = 1'b0;
    drain(20);
    chk("to_flag", timeout, 1);
`else
    chk("timeout_tied", timeout, 0);
`endif

    // reset in the middle of an N64 read
    mem_lat = 20;
    n64_edge(32'h1000_0400, 1, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_req_before", mem_if.mem_req, 1);
    #2 rst = 1'b1;
    n64_exp.delete();
    addr_exp.delete();
    #1;
    chk("rst_mid_req", mem_if.mem_req, 0);
    chk("rst_mid_valid", n64_data_valid, 0);
    chk("rst_mid_data", n64_data, 0);
    chk("rst_mid_overrun", overrun, 0);
    chk("rst_mid_timeout", timeout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n64_cnt;
    repeat (30) @(negedge clk);
    chk("rst_no_valid", n64_cnt - base, 0);

    mem_lat = 3;
    n64_edge(32'h1000_0010, 1, 0);
    drain(50);
    chk("sb_n64_empty", n64_exp.size(), 0);
    chk("sb_ldr_empty", ldr_exp.size(), 0);
    chk("sb_mem_empty", addr_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
